// File: rtl/otter_arb_pkg.sv
// Shared types for the otter instruction/data memory arbiter.
// Holds the FSM state and grant encodings plus the fair-pick helper.
package otter_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {GNT_IMEM, GNT_DMEM} arb_grant_t;

    localparam int ARB_CNT_W = 4;

    // When both ports are pending, the port that did not win last time goes next.
    function automatic arb_grant_t arb_pick(input logic ireq, input logic dreq,
                                            input logic last_dmem);
        if (ireq && dreq) begin
            return last_dmem ? GNT_IMEM : GNT_DMEM;
        end else if (dreq) begin
            return GNT_DMEM;
        end
        return GNT_IMEM;
    endfunction

endpackage

// File: rtl/otter_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between fetch and data ports.
// Latency MEM_LATENCY+2 from request to valid; one access in flight, no queueing.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_imem_req,
    input  logic [ADDR_WIDTH-1:0]   i_imem_addr,
    output logic [DATA_WIDTH-1:0]   o_imem_r_data,
    output logic                    o_imem_valid,
    input  logic                    i_dmem_re,
    input  logic                    i_dmem_we,
    input  logic [DATA_WIDTH/8-1:0] i_dmem_sel,
    input  logic [ADDR_WIDTH-1:0]   i_dmem_addr,
    input  logic [DATA_WIDTH-1:0]   i_dmem_w_data,
    output logic [DATA_WIDTH-1:0]   o_dmem_r_data,
    output logic                    o_dmem_valid,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH/8-1:0] o_mem_sel,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_w_data,
    input  logic [DATA_WIDTH-1:0]   i_mem_r_data,
    output logic                    o_busy
);

    arb_state_t           state_q;
    arb_grant_t           gnt_q;
    arb_grant_t           gnt_d;
    logic                 last_dmem_q;
    logic [ARB_CNT_W-1:0] cnt_q;
    logic                 dreq;

    assign dreq  = i_dmem_re | i_dmem_we;
    assign gnt_d = arb_pick(i_imem_req, dreq, last_dmem_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_IMEM;
            last_dmem_q   <= 1'b0;
            cnt_q         <= '0;
            o_imem_r_data <= '0;
            o_imem_valid  <= 1'b0;
            o_dmem_r_data <= '0;
            o_dmem_valid  <= 1'b0;
            o_mem_en      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_sel     <= '0;
            o_mem_addr    <= '0;
            o_mem_w_data  <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_imem_valid <= 1'b0;
            o_dmem_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_imem_req || dreq) begin
                        gnt_q       <= gnt_d;
                        last_dmem_q <= (gnt_d == GNT_DMEM);
                        o_mem_en    <= 1'b1;
                        o_busy      <= 1'b1;
                        state_q     <= ISSUE;
                        if (gnt_d == GNT_DMEM) begin
                            o_mem_we     <= i_dmem_we;
                            o_mem_sel    <= i_dmem_sel;
                            o_mem_addr   <= i_dmem_addr;
                            o_mem_w_data <= i_dmem_w_data;
                        end else begin
                            o_mem_we     <= 1'b0;
                            o_mem_sel    <= '1;
                            o_mem_addr   <= i_imem_addr;
                            o_mem_w_data <= '0;
                        end
                    end
                end
                ISSUE: begin
                    o_mem_en <= 1'b0;
                    cnt_q    <= ARB_CNT_W'(MEM_LATENCY - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // Command fields stay stable on the memory bus until the read returns.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - ARB_CNT_W'(1);
                    end else begin
                        state_q <= RESP;
                        if (gnt_q == GNT_DMEM) begin
                            o_dmem_r_data <= i_mem_r_data;
                            o_dmem_valid  <= 1'b1;
                        end else begin
                            o_imem_r_data <= i_mem_r_data;
                            o_imem_valid  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
